// File: rtl/rob_multi.sv
// Purpose: reorder buffer. Allocates in order from ID, captures results out of order from WB_PORTS
//          writeback ports, and retires up to COMMIT_W entries per cycle in order.
// Latency: writeback at edge E -> earliest commit (cm_valid) at edge E+1. cm_* are registered and held one cycle.
// Backpressure: alloc_ready=0 while count==DEPTH. Same-cycle retirements do not free a slot until the next cycle.
//
// Ports:
//   clk, rst                   clock; synchronous reset, active-low
//   flush                      (only with ROB_FLUSH_EN) discard all entries; rst has priority
//   alloc_valid/rd/op          allocation request from ID
//   alloc_ready/alloc_tag      slot available / tag granted (== tail)
//   wb_valid/wb_tag/wb_data    per-port results, port i at [i*W +: W]
//   cm_valid/tag/rd/data       retirement slots, filled contiguously from slot 0
//   bc_valid/bc_ready/bc_val   per-entry snoop vectors for reservation stations
//   count/empty                occupancy
// Optional feature macro: ROB_FLUSH_EN (adds the flush input).
module rob_multi #(
    parameter  int DEPTH    = 16,
    localparam int TAG_W    = $clog2(DEPTH),
    parameter  int DATA_W   = 32,
    parameter  int REG_W    = 5,
    parameter  int OP_W     = 8,
    parameter  int WB_PORTS = 2,
    parameter  int COMMIT_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef ROB_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         alloc_valid,
    input  logic [REG_W-1:0]             alloc_rd,
    input  logic [OP_W-1:0]              alloc_op,
    output logic                         alloc_ready,
    output logic [TAG_W-1:0]             alloc_tag,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
    output logic [COMMIT_W-1:0]          cm_valid,
    output logic [COMMIT_W*TAG_W-1:0]    cm_tag,
    output logic [COMMIT_W*REG_W-1:0]    cm_rd,
    output logic [COMMIT_W*DATA_W-1:0]   cm_data,
    output logic [DEPTH-1:0]             bc_valid,
    output logic [DEPTH-1:0]             bc_ready,
    output logic [DEPTH*DATA_W-1:0]      bc_val,
    output logic [TAG_W:0]               count,
    output logic                         empty
);

    localparam int CNT_W = TAG_W + 1;
    localparam int K_W   = $clog2(COMMIT_W + 1);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  ready_q;
    logic [DATA_W-1:0] val_q [DEPTH];
    logic [REG_W-1:0]  rd_q  [DEPTH];
    logic [OP_W-1:0]   op_q  [DEPTH];
    logic [TAG_W-1:0]  head_q;
    logic [TAG_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic [COMMIT_W-1:0]        cm_valid_q;
    logic [COMMIT_W*TAG_W-1:0]  cm_tag_q;
    logic [COMMIT_W*REG_W-1:0]  cm_rd_q;
    logic [COMMIT_W*DATA_W-1:0] cm_data_q;

    logic [TAG_W-1:0]           cidx [COMMIT_W];
    logic [COMMIT_W-1:0]        cm_valid_n;
    logic [COMMIT_W*TAG_W-1:0]  cm_tag_n;
    logic [COMMIT_W*REG_W-1:0]  cm_rd_n;
    logic [COMMIT_W*DATA_W-1:0] cm_data_n;
    logic [K_W-1:0]             k_cnt;
    logic                       stop;
    logic                       alloc_fire;
    logic [CNT_W-1:0]           count_next;

    // Status outputs come from registered state only.
    assign alloc_ready = (count_q != CNT_W'(DEPTH));
    assign alloc_tag   = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign bc_valid    = valid_q;
    assign bc_ready    = ready_q;
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign cm_valid    = cm_valid_q;
    assign cm_tag      = cm_tag_q;
    assign cm_rd       = cm_rd_q;
    assign cm_data     = cm_data_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            bc_val[i*DATA_W +: DATA_W] = val_q[i];
        end
    end

    // Candidate retirement indices; the tag width makes the addition wrap modulo DEPTH.
    always_comb begin
        for (int j = 0; j < COMMIT_W; j++) begin
            cidx[j] = head_q + TAG_W'(j);
        end
    end

    // Retire the run of valid&&ready entries starting at head; the first gap ends the run.
    // Entries past tail are invalid, so the run never exceeds the occupancy.
    always_comb begin
        cm_valid_n = '0;
        cm_tag_n   = '0;
        cm_rd_n    = '0;
        cm_data_n  = '0;
        k_cnt      = '0;
        stop       = 1'b0;
        for (int j = 0; j < COMMIT_W; j++) begin
            if (!stop && valid_q[cidx[j]] && ready_q[cidx[j]]) begin
                cm_valid_n[j]                    = 1'b1;
                cm_tag_n[j*TAG_W +: TAG_W]       = cidx[j];
                cm_rd_n[j*REG_W +: REG_W]        = rd_q[cidx[j]];
                cm_data_n[j*DATA_W +: DATA_W]    = val_q[cidx[j]];
                k_cnt                            = k_cnt + K_W'(1);
            end else begin
                stop = 1'b1;
            end
        end
    end

    assign count_next = count_q + CNT_W'(alloc_fire) - CNT_W'(k_cnt);

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= '0;
            ready_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            cm_valid_q <= '0;
            cm_tag_q   <= '0;
            cm_rd_q    <= '0;
            cm_data_q  <= '0;
`ifdef ROB_FLUSH_EN
        end else if (flush) begin
            valid_q    <= '0;
            ready_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            cm_valid_q <= '0;
            cm_tag_q   <= '0;
            cm_rd_q    <= '0;
            cm_data_q  <= '0;
`endif
        end else begin
            cm_valid_q <= cm_valid_n;
            cm_tag_q   <= cm_tag_n;
            cm_rd_q    <= cm_rd_n;
            cm_data_q  <= cm_data_n;

            // Later ports are assigned last, so the highest port index wins on a tag clash.
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && valid_q[wb_tag[p*TAG_W +: TAG_W]]) begin
                    ready_q[wb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
                    val_q[wb_tag[p*TAG_W +: TAG_W]]   <= wb_data[p*DATA_W +: DATA_W];
                end
            end

            // Retirement decided on pre-edge ready; it overrides a same-cycle writeback to that entry.
            for (int j = 0; j < COMMIT_W; j++) begin
                if (cm_valid_n[j]) begin
                    valid_q[cidx[j]] <= 1'b0;
                    ready_q[cidx[j]] <= 1'b0;
                end
            end

            // Tail is never a slot retired this cycle: a full ROB blocks allocation.
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                rd_q[tail_q]    <= alloc_rd;
                op_q[tail_q]    <= alloc_op;
                tail_q          <= tail_q + TAG_W'(1);
            end

            head_q  <= head_q + TAG_W'(k_cnt);
            count_q <= count_next;
        end
    end

endmodule

// File: tb/tb_rob_multi.sv
// Purpose: self-checking bench for rob_multi (DEPTH=16, WB_PORTS=2, COMMIT_W=2) against an in-order queue model.
// Latency: inputs driven just after a posedge, outputs sampled 1 time unit after the next posedge.
// Backpressure: model refuses allocation when 16 entries are held, matching alloc_ready.
module tb_rob_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_rd = '0;
    logic [7:0]  alloc_op = '0;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic [1:0]  wb_valid = '0;
    logic [7:0]  wb_tag = '0;
    logic [63:0] wb_data = '0;
    logic [1:0]  cm_valid;
    logic [7:0]  cm_tag;
    logic [9:0]  cm_rd;
    logic [63:0] cm_data;
    logic [15:0] bc_valid;
    logic [15:0] bc_ready;
    logic [511:0] bc_val;
    logic [4:0]  count;
    logic        empty;

    int vectors = 0;
    int miscompares = 0;

    rob_multi dut (
        .clk(clk), .rst(rst),
`ifdef ROB_FLUSH_EN
        .flush(flush),
`endif
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_op(alloc_op),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .cm_valid(cm_valid), .cm_tag(cm_tag), .cm_rd(cm_rd), .cm_data(cm_data),
        .bc_valid(bc_valid), .bc_ready(bc_ready), .bc_val(bc_val),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference model: program-order list of in-flight instructions.
    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        bit          rdy;
        logic [31:0] val;
    } ent_t;

    ent_t        q[$];
    int          m_tail;
    logic [1:0]  e_cmv;
    logic [3:0]  e_cmt [2];
    logic [4:0]  e_cmr [2];
    logic [31:0] e_cmd [2];

    task automatic model_reset();
        q.delete();
        m_tail = 0;
        e_cmv  = 2'b00;
    endtask

    task automatic model_step(input bit a, input logic [4:0] r, input logic [1:0] wv,
                              input logic [3:0] t0, input logic [31:0] d0,
                              input logic [3:0] t1, input logic [31:0] d1);
        int  k;
        bit  fire;
        logic [3:0]  wt [2];
        logic [31:0] wd [2];
        ent_t e;
        wt[0] = t0; wt[1] = t1; wd[0] = d0; wd[1] = d1;
        k = 0;
        e_cmv = 2'b00;
        for (int j = 0; j < 2; j++) begin
            if (k == j && j < q.size() && q[j].rdy) begin
                e_cmv[j] = 1'b1;
                e_cmt[j] = q[j].tag;
                e_cmr[j] = q[j].rd;
                e_cmd[j] = q[j].val;
                k++;
            end
        end
        fire = a && (q.size() < 16);
        for (int p = 0; p < 2; p++) begin
            if (wv[p]) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].tag == wt[p]) begin
                        q[i].rdy = 1'b1;
                        q[i].val = wd[p];
                    end
                end
            end
        end
        for (int j = 0; j < k; j++) void'(q.pop_front());
        if (fire) begin
            e.tag = 4'(m_tail); e.rd = r; e.rdy = 1'b0; e.val = '0;
            q.push_back(e);
            m_tail = (m_tail + 1) % 16;
        end
    endtask

    task automatic drive(input bit a, input logic [4:0] r, input logic [1:0] wv,
                         input logic [3:0] t0, input logic [31:0] d0,
                         input logic [3:0] t1, input logic [31:0] d1);
        alloc_valid = a;
        alloc_rd    = r;
        alloc_op    = 8'($urandom);
        wb_valid    = wv;
        wb_tag      = {t1, t0};
        wb_data     = {d1, d0};
        model_step(a, r, wv, t0, d0, t1, d1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        alloc_valid = 1'b0;
        wb_valid = 2'b00;
        flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1 || alloc_ready !== 1'b1 || alloc_tag !== 4'd0 ||
            cm_valid !== 2'b00 || bc_valid !== 16'h0 || bc_ready !== 16'h0) begin
            miscompares++;
            $display("FAIL reset: count=%0d empty=%b ardy=%b atag=%0d cmv=%b bcv=%h bcr=%h want 0 1 1 0 00 0000 0000",
                     count, empty, alloc_ready, alloc_tag, cm_valid, bc_valid, bc_ready);
        end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (alloc_tag !== 4'(i)) begin
                miscompares++;
                $display("FAIL fill_tag: got %0d want %0d", alloc_tag, i);
            end
            drive(1'b1, 5'(i), 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        end
        vectors++;
        if (count !== 5'd16 || alloc_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: count=%0d ardy=%b want 16 0", count, alloc_ready);
        end
        drive(1'b1, 5'd31, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        vectors++;
        if (count !== 5'd16 || alloc_tag !== 4'd0 || bc_valid !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL fill_17th: count=%0d atag=%0d bcv=%h want 16 0 ffff", count, alloc_tag, bc_valid);
        end
    endtask

    task automatic test_inorder();
        apply_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 5'(i + 1), 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        drive(1'b0, 5'd0, 2'b01, 4'd2, 32'hC, 4'd0, 32'd0);
        drive(1'b0, 5'd0, 2'b01, 4'd1, 32'hB, 4'd0, 32'd0);
        vectors++;
        if (cm_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL inorder_gap: cmv=%b want 00", cm_valid);
        end
        drive(1'b0, 5'd0, 2'b10, 4'd0, 32'd0, 4'd0, 32'hA);
        vectors++;
        if (cm_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL inorder_wb_latency: cmv=%b want 00", cm_valid);
        end
        idle();
        vectors++;
        if (cm_valid !== 2'b11 || cm_tag !== 8'h10 || cm_rd[4:0] !== 5'd1 || cm_rd[9:5] !== 5'd2 ||
            cm_data !== {32'hB, 32'hA}) begin
            miscompares++;
            $display("FAIL inorder_pair: cmv=%b tag=%h rd=%h data=%h want 11 10 041 0000000b0000000a",
                     cm_valid, cm_tag, cm_rd, cm_data);
        end
        idle();
        vectors++;
        if (cm_valid !== 2'b01 || cm_tag[3:0] !== 4'd2 || cm_data[31:0] !== 32'hC || cm_rd[4:0] !== 5'd3) begin
            miscompares++;
            $display("FAIL inorder_last: cmv=%b tag=%0d data=%h rd=%0d want 01 2 c 3",
                     cm_valid, cm_tag[3:0], cm_data[31:0], cm_rd[4:0]);
        end
        idle();
        vectors++;
        if (cm_valid !== 2'b00 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL inorder_drain: cmv=%b empty=%b want 00 1", cm_valid, empty);
        end
    endtask

    task automatic test_wb_conflict();
        apply_reset();
        for (int i = 0; i < 6; i++) drive(1'b1, 5'(i), 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        drive(1'b0, 5'd0, 2'b11, 4'd5, 32'h11, 4'd5, 32'h22);
        vectors++;
        if (bc_val[5*32 +: 32] !== 32'h22 || bc_ready !== 16'h0020 || cm_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL wb_conflict: val=%h bcr=%h cmv=%b want 22 0020 00", bc_val[5*32 +: 32], bc_ready, cm_valid);
        end
        drive(1'b0, 5'd0, 2'b01, 4'd5, 32'h33, 4'd0, 32'd0);
        vectors++;
        if (bc_val[5*32 +: 32] !== 32'h33) begin
            miscompares++;
            $display("FAIL wb_overwrite: val=%h want 33", bc_val[5*32 +: 32]);
        end
        drive(1'b0, 5'd0, 2'b01, 4'd9, 32'h44, 4'd0, 32'd0);
        vectors++;
        if (bc_ready !== 16'h0020) begin
            miscompares++;
            $display("FAIL wb_invalid_entry: bcr=%h want 0020", bc_ready);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 14; i++) drive(1'b1, 5'(i), 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 5'd0, 2'b11, 4'(2*i), 32'(100 + 2*i), 4'(2*i + 1), 32'(101 + 2*i));
            vectors++;
            if (cm_valid !== e_cmv || (e_cmv[0] && cm_tag[3:0] !== e_cmt[0])) begin
                miscompares++;
                $display("FAIL wrap_drain: cmv=%b tag0=%0d want %b %0d", cm_valid, cm_tag[3:0], e_cmv, e_cmt[0]);
            end
        end
        for (int i = 0; i < 3; i++) idle();
        vectors++;
        if (count !== 5'd0 || alloc_tag !== 4'd14) begin
            miscompares++;
            $display("FAIL wrap_empty: count=%0d atag=%0d want 0 14", count, alloc_tag);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (alloc_tag !== 4'((14 + i) % 16)) begin
                miscompares++;
                $display("FAIL wrap_tag: got %0d want %0d", alloc_tag, (14 + i) % 16);
            end
            drive(1'b1, 5'(20 + i), 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        end
        drive(1'b0, 5'd0, 2'b11, 4'd0, 32'hF0, 4'd15, 32'hFF);
        drive(1'b0, 5'd0, 2'b11, 4'd1, 32'hF1, 4'd14, 32'hFE);
        for (int c = 0; c < 3; c++) begin
            idle();
            vectors++;
            if (cm_valid !== e_cmv || (e_cmv[0] && (cm_tag[3:0] !== e_cmt[0] || cm_data[31:0] !== e_cmd[0])) ||
                (e_cmv[1] && (cm_tag[7:4] !== e_cmt[1] || cm_data[63:32] !== e_cmd[1])) ||
                count !== 5'(q.size())) begin
                miscompares++;
                $display("FAIL wrap_commit: cmv=%b tag=%h count=%0d want %b %h%h %0d",
                         cm_valid, cm_tag, count, e_cmv, e_cmt[1], e_cmt[0], q.size());
            end
        end
    endtask

    task automatic test_full_retire();
        apply_reset();
        for (int i = 0; i < 16; i++) drive(1'b1, 5'(i), 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        drive(1'b0, 5'd0, 2'b01, 4'd0, 32'h5A, 4'd0, 32'd0);
        drive(1'b1, 5'd7, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        vectors++;
        if (cm_valid !== 2'b01 || cm_tag[3:0] !== 4'd0 || count !== 5'd15 || alloc_ready !== 1'b1 ||
            alloc_tag !== 4'd0) begin
            miscompares++;
            $display("FAIL full_stall: cmv=%b tag=%0d count=%0d ardy=%b atag=%0d want 01 0 15 1 0",
                     cm_valid, cm_tag[3:0], count, alloc_ready, alloc_tag);
        end
        drive(1'b1, 5'd7, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        vectors++;
        if (count !== 5'd16 || bc_valid[0] !== 1'b1 || alloc_ready !== 1'b0 || alloc_tag !== 4'd1) begin
            miscompares++;
            $display("FAIL full_regrant: count=%0d bcv0=%b ardy=%b atag=%0d want 16 1 0 1",
                     count, bc_valid[0], alloc_ready, alloc_tag);
        end
    endtask

    task automatic test_midop_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 5'(i), 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        drive(1'b0, 5'd0, 2'b11, 4'd0, 32'h1, 4'd1, 32'h2);
        rst = 1'b0;
        alloc_valid = 1'b1;
        wb_valid = 2'b11;
        wb_tag = {4'd3, 4'd2};
        @(posedge clk);
        #1;
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1 || cm_valid !== 2'b00 || alloc_tag !== 4'd0 || bc_valid !== 16'h0) begin
            miscompares++;
            $display("FAIL midop_reset: count=%0d empty=%b cmv=%b atag=%0d bcv=%h want 0 1 00 0 0000",
                     count, empty, cm_valid, alloc_tag, bc_valid);
        end
        rst = 1'b1;
        model_reset();
    endtask

`ifdef ROB_FLUSH_EN
    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 5'(i), 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        drive(1'b0, 5'd0, 2'b11, 4'd0, 32'h1, 4'd1, 32'h2);
        flush = 1'b1;
        alloc_valid = 1'b1;
        wb_valid = 2'b11;
        wb_tag = {4'd3, 4'd2};
        @(posedge clk);
        #1;
        flush = 1'b0;
        model_reset();
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1 || cm_valid !== 2'b00 || alloc_tag !== 4'd0 || bc_valid !== 16'h0) begin
            miscompares++;
            $display("FAIL flush: count=%0d empty=%b cmv=%b atag=%0d bcv=%h want 0 1 00 0 0000",
                     count, empty, cm_valid, alloc_tag, bc_valid);
        end
        drive(1'b1, 5'd9, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        vectors++;
        if (bc_valid !== 16'h0001 || count !== 5'd1) begin
            miscompares++;
            $display("FAIL flush_realloc: bcv=%h count=%0d want 0001 1", bc_valid, count);
        end
    endtask
`endif

    task automatic test_random();
        logic [15:0] ev, er;
        logic [3:0]  t [2];
        bit          a;
        logic [1:0]  wv;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            a = ($urandom_range(0, 9) < 6);
            for (int p = 0; p < 2; p++) begin
                if (q.size() > 0 && $urandom_range(0, 4) != 0)
                    t[p] = q[$urandom_range(0, q.size() - 1)].tag;
                else
                    t[p] = 4'($urandom_range(0, 15));
            end
            wv = 2'($urandom_range(0, 3));
            drive(a, 5'($urandom), wv, t[0], $urandom, t[1], $urandom);
            ev = '0;
            er = '0;
            for (int i = 0; i < q.size(); i++) begin
                ev[q[i].tag] = 1'b1;
                if (q[i].rdy) er[q[i].tag] = 1'b1;
            end
            vectors++;
            if (cm_valid !== e_cmv) begin
                miscompares++;
                $display("FAIL rnd_cm_valid c=%0d: got %b want %b", c, cm_valid, e_cmv);
            end
            for (int j = 0; j < 2; j++) begin
                if (e_cmv[j]) begin
                    vectors++;
                    if (cm_tag[j*4 +: 4] !== e_cmt[j] || cm_rd[j*5 +: 5] !== e_cmr[j] ||
                        cm_data[j*32 +: 32] !== e_cmd[j]) begin
                        miscompares++;
                        $display("FAIL rnd_cm_slot%0d c=%0d: tag=%0d rd=%0d data=%h want %0d %0d %h", j, c,
                                 cm_tag[j*4 +: 4], cm_rd[j*5 +: 5], cm_data[j*32 +: 32], e_cmt[j], e_cmr[j], e_cmd[j]);
                    end
                end
            end
            vectors++;
            if (count !== 5'(q.size()) || empty !== (q.size() == 0) || alloc_ready !== (q.size() < 16) ||
                alloc_tag !== 4'(m_tail) || bc_valid !== ev || bc_ready !== er) begin
                miscompares++;
                $display("FAIL rnd_state c=%0d: count=%0d atag=%0d bcv=%h bcr=%h want %0d %0d %h %h",
                         c, count, alloc_tag, bc_valid, bc_ready, q.size(), m_tail, ev, er);
            end
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].rdy) begin
                    vectors++;
                    if (bc_val[q[i].tag*32 +: 32] !== q[i].val) begin
                        miscompares++;
                        $display("FAIL rnd_bc_val c=%0d tag=%0d: got %h want %h", c, q[i].tag,
                                 bc_val[q[i].tag*32 +: 32], q[i].val);
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_inorder();
        test_wb_conflict();
        test_wrap();
        test_full_retire();
        test_midop_reset();
`ifdef ROB_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
